// File: rtl/cronometro_pkg.sv
// Shared state encodings and elaboration-time sizing helpers for the stopwatch run-control block.
package cronometro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Bits needed to hold values 0..count-1 (never less than one bit).
  function automatic int width_for(input int count);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(count)) w++;
    return w;
  endfunction

endpackage

// File: rtl/controle_cronometro_debounce.sv
// Pushbutton conditioner: two-stage synchronizer, stability counter and a one-cycle press pulse.
module debounce_botao
  import cronometro_pkg::*;
#(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = width_for(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // Any sample matching the accepted level restarts the count; only a full run flips it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level      <= 1'b1;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_b == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        level      <= sync_b;
        stable_cnt <= '0;
        press      <= ~sync_b;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/controle_cronometro.sv
// Stopwatch run-control: debounced buttons drive an IDLE/RUN/PAUSE/LAP sequencer that
// produces the count-enable tick, counter clear pulse and display-hold level.
module controle_cronometro
  import cronometro_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic       CLK_IN,
  input  logic       RST_N,
  input  logic       BTN_START,
  input  logic       BTN_LAP,
  input  logic       BTN_CLR,
  input  logic       MAX_REACHED,
  output logic       TICK_EN,
  output logic       CNT_CLR,
  output logic       LAP_HOLD,
  output logic [1:0] STATE,
  output logic       RUN_LED
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = width_for(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic ev_start;
  logic ev_lap;
  logic ev_clr;

  debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk(CLK_IN), .rst_n(RST_N), .btn_raw(BTN_START), .press(ev_start)
  );

  debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk(CLK_IN), .rst_n(RST_N), .btn_raw(BTN_LAP), .press(ev_lap)
  );

  debounce_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk(CLK_IN), .rst_n(RST_N), .btn_raw(BTN_CLR), .press(ev_clr)
  );

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          pending_clr_q;
  logic          running;
  logic          terminal;
  logic          tick_d;
  logic          clr_d;

  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      presc_q       <= '0;
      pending_clr_q <= 1'b1;
      TICK_EN       <= 1'b0;
      CNT_CLR       <= 1'b0;
      LAP_HOLD      <= 1'b0;
      RUN_LED       <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      pending_clr_q <= 1'b0;
      TICK_EN       <= tick_d;
      CNT_CLR       <= clr_d;
      LAP_HOLD      <= (state_d == ST_LAP);
      RUN_LED       <= (state_d == ST_RUN) || (state_d == ST_LAP);
    end
  end

  // Event priority CLR > START > LAP falls out of the if/else ordering in each state.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    clr_d    = 1'b0;
    running  = (state_q == ST_RUN) || (state_q == ST_LAP);
    terminal = running && (presc_q == PRESC_LAST);

    if (running) begin
      presc_d = terminal ? '0 : presc_q + 1'b1;
    end

    if (terminal && MAX_REACHED) begin
      state_d = ST_PAUSE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ev_clr)        clr_d   = 1'b1;
          else if (ev_start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (ev_start)    state_d = ST_PAUSE;
          else if (ev_lap) state_d = ST_LAP;
        end
        ST_LAP: begin
          if (ev_start)    state_d = ST_PAUSE;
          else if (ev_lap) state_d = ST_RUN;
        end
        ST_PAUSE: begin
          if (ev_clr) begin
            state_d = ST_IDLE;
            clr_d   = 1'b1;
            presc_d = '0;
          end else if (ev_start && !MAX_REACHED) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A tick landing on the same cycle as a pause is dropped so TICK_EN never shows in PAUSE.
    tick_d = terminal && ((state_d == ST_RUN) || (state_d == ST_LAP));

    if (pending_clr_q) clr_d = 1'b1;
  end

  assign STATE = state_q;

endmodule

// File: tb/tb_controle_cronometro.sv
// Self-checking bench for controle_cronometro: directed scenarios plus random button/MAX traffic
// compared every cycle against a window-based behavioural model.
module tb_controle_cronometro;

  localparam int DIV = 10;
  localparam int DEB = 4;
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b1;
  logic       btn_lap = 1'b1;
  logic       btn_clr = 1'b1;
  logic       max_reached = 1'b0;
  logic       tick_en;
  logic       cnt_clr;
  logic       lap_hold;
  logic       run_led;
  logic [1:0] state;
  logic [5:0] dut_vec;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  controle_cronometro #(
    .CLK_HZ(100), .TICK_HZ(10), .DEB_CYCLES(DEB)
  ) dut (
    .CLK_IN(clk), .RST_N(rst_n), .BTN_START(btn_start), .BTN_LAP(btn_lap),
    .BTN_CLR(btn_clr), .MAX_REACHED(max_reached), .TICK_EN(tick_en), .CNT_CLR(cnt_clr),
    .LAP_HOLD(lap_hold), .STATE(state), .RUN_LED(run_led)
  );

  assign dut_vec = {state, tick_en, cnt_clr, lap_hold, run_led};

  // Reference model: a button level is accepted once the last DEB synchronised samples
  // (raw delayed two clocks) all disagree with it; a press event is visible one cycle later.
  logic [1:0]     m_state;
  int             m_presc;
  logic           m_tick;
  logic           m_clr;
  logic           m_pending;
  logic [DEB+1:0] hist [3];
  logic           m_level [3];
  logic           m_ev [3];

  always @(posedge clk) begin : model
    logic           raw [3];
    logic           s, l, c, running, terminal;
    logic [DEB-1:0] win;
    raw[0] = btn_start;
    raw[1] = btn_lap;
    raw[2] = btn_clr;
    if (!rst_n) begin
      m_state   = S_IDLE;
      m_presc   = 0;
      m_tick    = 1'b0;
      m_clr     = 1'b0;
      m_pending = 1'b1;
      for (int b = 0; b < 3; b++) begin
        hist[b]    = '1;
        m_level[b] = 1'b1;
        m_ev[b]    = 1'b0;
      end
    end else begin
      s = m_ev[0];
      l = m_ev[1];
      c = m_ev[2];
      m_tick    = 1'b0;
      m_clr     = m_pending;
      m_pending = 1'b0;
      running   = (m_state == S_RUN) || (m_state == S_LAP);
      terminal  = running && (m_presc == DIV - 1);
      if (running) m_presc = (m_presc + 1) % DIV;
      if (terminal && max_reached) begin
        m_state = S_PAUSE;
      end else begin
        case (m_state)
          S_IDLE: if (c) m_clr = 1'b1; else if (s) m_state = S_RUN;
          S_RUN:  if (s) m_state = S_PAUSE; else if (l) m_state = S_LAP;
          S_LAP:  if (s) m_state = S_PAUSE; else if (l) m_state = S_RUN;
          default: begin
            if (c) begin
              m_state = S_IDLE;
              m_clr   = 1'b1;
              m_presc = 0;
            end else if (s && !max_reached) begin
              m_state = S_RUN;
            end
          end
        endcase
      end
      if (terminal && ((m_state == S_RUN) || (m_state == S_LAP))) m_tick = 1'b1;
      for (int b = 0; b < 3; b++) begin
        hist[b] = {hist[b][DEB:0], raw[b]};
        win     = hist[b][DEB+1:2];
        m_ev[b] = 1'b0;
        if (win == {DEB{~m_level[b]}}) begin
          m_level[b] = ~m_level[b];
          m_ev[b]    = ~m_level[b];
        end
      end
    end
  end

  function automatic logic [5:0] model_vec();
    return {m_state, m_tick, m_clr, m_state == S_LAP, (m_state == S_RUN) || (m_state == S_LAP)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== 6'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs cyc=%0d got=%b want=000000", i, dut_vec);
      end
      btn_start = 1'($urandom_range(0, 1));
    end
    btn_start = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (cnt_clr !== (i == 0)) begin
        n_fail++;
        $display("[TB] FAIL reset_cnt_clr cyc=%0d got=%b want=%b", i, cnt_clr, i == 0);
      end
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL reset_model cyc=%0d got=%b want=%b", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_start_run();
    int ticks;
    ticks = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL start_model cyc=%0d got=%b want=%b", i, dut_vec, model_vec());
      end
      if (i == 6 || i == 7) begin
        n_checks++;
        if (state !== ((i == 7) ? S_RUN : S_IDLE)) begin
          n_fail++;
          $display("[TB] FAIL start_latency cyc=%0d got=%b want=%b", i, state,
                   (i == 7) ? S_RUN : S_IDLE);
        end
      end
      if (tick_en === 1'b1) ticks++;
      btn_start = !(i < 10);
    end
    n_checks++;
    if (ticks !== (59 - 7) / DIV) begin
      n_fail++;
      $display("[TB] FAIL start_tick_count got=%0d want=%0d", ticks, (59 - 7) / DIV);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL bounce_model cyc=%0d got=%b want=%b", i, dut_vec, model_vec());
      end
      btn_start = (i < 30) ? 1'(((i / 2) % 2) == 0) : 1'b1;
    end
    n_checks++;
    if (state !== S_RUN) begin
      n_fail++;
      $display("[TB] FAIL bounce_state got=%b want=%b", state, S_RUN);
    end
  endtask

  task automatic test_pause_resume();
    int run_cyc, tick_cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL pause_wait cyc=%0d got=%b want=%b", i, dut_vec, model_vec());
      end
      if (m_presc == DIV - 1) break;
    end
    for (int i = 0; i < 70; i++) begin
      btn_start = !(i < 10);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL pause_model cyc=%0d got=%b want=%b", i, dut_vec, model_vec());
      end
      if (i >= 8) begin
        n_checks++;
        if (state !== S_PAUSE || tick_en !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL pause_hold cyc=%0d got state=%b tick=%b want state=10 tick=0",
                   i, state, tick_en);
        end
      end
    end
    run_cyc  = -1;
    tick_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      btn_start = !(i < 10);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL resume_model cyc=%0d got=%b want=%b", i, dut_vec, model_vec());
      end
      if (run_cyc < 0 && m_state == S_RUN) run_cyc = i;
      if (run_cyc >= 0 && tick_cyc < 0 && tick_en === 1'b1) tick_cyc = i;
    end
    n_checks++;
    if (tick_cyc - run_cyc !== DIV - 6) begin
      n_fail++;
      $display("[TB] FAIL resume_first_tick got=%0d want=%0d", tick_cyc - run_cyc, DIV - 6);
    end
  endtask

  task automatic test_lap();
    int dut_ticks, exp_ticks;
    dut_ticks = 0;
    exp_ticks = 0;
    for (int i = 0; i < 30; i++) begin
      btn_lap = !(i < 6);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL lap_model cyc=%0d got=%b want=%b", i, dut_vec, model_vec());
      end
      if (i >= 7) begin
        if (tick_en === 1'b1) dut_ticks++;
        if (m_tick) exp_ticks++;
        n_checks++;
        if (state !== S_LAP || lap_hold !== 1'b1 || run_led !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL lap_enter cyc=%0d got=%b%b%b want=1111", i, state, lap_hold, run_led);
        end
      end
    end
    n_checks++;
    if (dut_ticks !== exp_ticks || exp_ticks == 0) begin
      n_fail++;
      $display("[TB] FAIL lap_ticks got=%0d want=%0d", dut_ticks, exp_ticks);
    end
    for (int i = 0; i < 20; i++) begin
      btn_lap = !(i < 6);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL lap_exit_model cyc=%0d got=%b want=%b", i, dut_vec, model_vec());
      end
    end
    n_checks++;
    if (state !== S_RUN || lap_hold !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL lap_exit got=%b%b want=010", state, lap_hold);
    end
  endtask

  task automatic test_saturation();
    int clr_pulses;
    max_reached = 1'b1;
    for (int i = 0; i < 35; i++) begin
      btn_start = !(i >= 15 && i < 25);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL sat_model cyc=%0d got=%b want=%b", i, dut_vec, model_vec());
      end
      if (i >= 1) begin
        n_checks++;
        if (tick_en !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL sat_tick cyc=%0d got=%b want=0", i, tick_en);
        end
      end
    end
    n_checks++;
    if (state !== S_PAUSE) begin
      n_fail++;
      $display("[TB] FAIL sat_state got=%b want=%b", state, S_PAUSE);
    end
    clr_pulses = 0;
    for (int i = 0; i < 25; i++) begin
      btn_start = !(i < 10);
      btn_clr   = !(i < 10);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL clr_model cyc=%0d got=%b want=%b", i, dut_vec, model_vec());
      end
      if (cnt_clr === 1'b1) clr_pulses++;
    end
    n_checks++;
    if (clr_pulses !== 1 || state !== S_IDLE) begin
      n_fail++;
      $display("[TB] FAIL clr_pulse got pulses=%0d state=%b want pulses=1 state=00",
               clr_pulses, state);
    end
    max_reached = 1'b0;
  endtask

  task automatic test_random();
    int rem [3];
    for (int b = 0; b < 3; b++) rem[b] = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("[TB] FAIL random_model cyc=%0d got=%b want=%b", i, dut_vec, model_vec());
      end
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
      for (int b = 0; b < 3; b++) begin
        if (rem[b] > 0) rem[b]--;
        else if ($urandom_range(0, 39) == 0) rem[b] = int'($urandom_range(1, 14));
      end
      btn_start = (rem[0] == 0);
      btn_lap   = (rem[1] == 0);
      btn_clr   = (rem[2] == 0);
      if ($urandom_range(0, 99) == 0) max_reached = ~max_reached;
    end
    btn_start   = 1'b1;
    btn_lap     = 1'b1;
    btn_clr     = 1'b1;
    max_reached = 1'b0;
    rst_n       = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start_run();
    test_bounce();
    test_pause_resume();
    test_lap();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
